// File: rtl/spi_pkg.sv
// Shared types, constants and helpers for the SPI master controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    localparam logic [23:0] FIRST_MSB = "MSB";
    localparam logic [23:0] FIRST_LSB = "LSB";

    // Cycles from the accept cycle to the done cycle of one transfer.
    function automatic int spi_xfer_cycles(input int width, input int half_period);
        return 1 + half_period * (2 * width + 3);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timebase: a reloadable down-counter that pulses tick once
// every HALF_PERIOD cycles; clear holds it at the start of a fresh interval.
module spi_tick_gen #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;

    // Count down to zero, reloading on expiry or when the interval is restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (clear || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !clear;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: sequences cs setup, 2*WIDTH sck half-periods, cs hold and an
// inter-transfer gap for one full-duplex word per accepted start request.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [23:0] FIRST_BIT   = "MSB",
    parameter logic        CPOL        = 1'b0,
    parameter logic        CPHA        = 1'b0,
    parameter int          HALF_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             cs
);

    localparam int EW = $clog2(2 * WIDTH);
    localparam logic [EW-1:0] LAST_HALF = EW'(2 * WIDTH - 1);
    localparam logic [EW-1:0] LAST_TRAIL_FROM = EW'(2 * WIDTH - 2);
    localparam bit MSB_FIRST = (FIRST_BIT == FIRST_MSB);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("spi_master_ctrl: WIDTH must be at least 2");
        end
        if (HALF_PERIOD < 1) begin : g_bad_half_period
            $error("spi_master_ctrl: HALF_PERIOD must be at least 1");
        end
        if ((FIRST_BIT != FIRST_MSB) && (FIRST_BIT != FIRST_LSB)) begin : g_bad_first_bit
            $error("spi_master_ctrl: FIRST_BIT must be MSB or LSB");
        end
    endgenerate

    spi_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic [EW-1:0]    edge_cnt;
    logic             tick;

    // Bit that goes out next on mosi for the selected bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Shift the word one place toward the outgoing end, taking in one miso bit.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
        return MSB_FIRST ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
    endfunction

    spi_tick_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state == IDLE),
        .tick (tick)
    );

    // Transfer sequencer; all pin-facing outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sck      <= CPOL;
            cs       <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            shreg    <= '0;
            edge_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= tx_data;
                        cs    <= 1'b0;
                        busy  <= 1'b1;
                        state <= SETUP;
                        if (!CPHA) begin
                            mosi <= first_bit(tx_data);
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state    <= SHIFT;
                        sck      <= ~CPOL;
                        edge_cnt <= '0;
                        if (!CPHA) begin
                            shreg <= shift_in(shreg, miso);
                        end else begin
                            mosi <= first_bit(shreg);
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (edge_cnt == LAST_HALF) begin
                            state <= HOLD;
                            sck   <= CPOL;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                            sck      <= ~sck;
                            if (edge_cnt[0]) begin
                                if (!CPHA) begin
                                    shreg <= shift_in(shreg, miso);
                                end else begin
                                    mosi <= first_bit(shreg);
                                end
                            end else begin
                                if (CPHA) begin
                                    shreg <= shift_in(shreg, miso);
                                end else if (edge_cnt != LAST_TRAIL_FROM) begin
                                    mosi <= first_bit(shreg);
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs    <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= shreg;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: five differently configured masters, each paired
// with a behavioural loopback slave and a timing model derived from the
// protocol rules, plus directed transfers with hand-computed results.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int          NU = 5;
    localparam int          CFG_W[NU]    = '{8, 12, 16, 32, 8};
    localparam logic [23:0] CFG_FB[NU]   = '{"MSB", "LSB", "MSB", "LSB", "MSB"};
    localparam logic        CFG_CPOL[NU] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic        CFG_CPHA[NU] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam int          CFG_HP[NU]   = '{4, 4, 4, 4, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start_v[NU];
    logic [31:0] tx_v[NU];
    logic [31:0] slave_tx[NU];
    logic [31:0] srx_v[NU];
    int          lead_cnt[NU];

    wire         cs_v[NU];
    wire         sck_v[NU];
    wire         mosi_v[NU];
    wire         busy_v[NU];
    wire         done_v[NU];
    wire  [31:0] rx_v[NU];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    for (genvar g = 0; g < NU; g++) begin : g_u
        localparam int          W  = CFG_W[g];
        localparam logic [23:0] FB = CFG_FB[g];
        localparam logic        CP = CFG_CPOL[g];
        localparam logic        CH = CFG_CPHA[g];
        localparam int          HP = CFG_HP[g];
        localparam int          L  = spi_xfer_cycles(W, HP);

        logic [W-1:0] rx_w;
        logic         cs_w, sck_w, mosi_w, busy_w, done_w;
        logic         s_miso = 1'b0;

        spi_master_ctrl #(
            .WIDTH(W), .FIRST_BIT(FB), .CPOL(CP), .CPHA(CH), .HALF_PERIOD(HP)
        ) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_v[g]),
            .tx_data(tx_v[g][W-1:0]),
            .rx_data(rx_w),
            .busy   (busy_w),
            .done   (done_w),
            .sck    (sck_w),
            .mosi   (mosi_w),
            .miso   (s_miso),
            .cs     (cs_w)
        );

        assign cs_v[g]   = cs_w;
        assign sck_v[g]  = sck_w;
        assign mosi_v[g] = mosi_w;
        assign busy_v[g] = busy_w;
        assign done_v[g] = done_w;
        assign rx_v[g]   = 32'(rx_w);

        // n-th bit in transmission order of a word
        function automatic logic bit_at(input logic [W-1:0] w, input int n);
            if (FB == "MSB") return w[W-1-n];
            return w[n];
        endfunction

        // Behavioural slave: presents its word on miso and collects mosi,
        // driven purely by cs and sck edges.
        logic [W-1:0] s_word = '0;
        logic [W-1:0] s_rx = '0;
        int           s_idx = 0;
        logic         cs_q = 1'b1;
        logic         sck_q = CP;
        logic         lead;
        always @(sck_w or cs_w) begin
            if (cs_w === 1'b0 && cs_q !== 1'b0 && rst_n === 1'b1) begin
                s_word = slave_tx[g][W-1:0];
                s_rx = '0;
                s_idx = 0;
                lead_cnt[g] = 0;
                if (!CH) s_miso = bit_at(s_word, 0);
            end else if (sck_w !== sck_q && cs_w === 1'b0 && rst_n === 1'b1) begin
                lead = (sck_w !== CP);
                if (lead) lead_cnt[g]++;
                if (lead == !CH) begin
                    if (FB == "MSB") s_rx = {s_rx[W-2:0], mosi_w};
                    else s_rx = {mosi_w, s_rx[W-1:1]};
                    srx_v[g] = 32'(s_rx);
                end else if (!CH) begin
                    s_idx++;
                    if (s_idx < W) s_miso = bit_at(s_word, s_idx);
                end else begin
                    if (s_idx < W) s_miso = bit_at(s_word, s_idx);
                    s_idx++;
                end
            end
            cs_q = cs_w;
            sck_q = sck_w;
        end

        // Transfer model: rel is the cycle index relative to the accept cycle
        // (-1 when no transfer is in flight), from which every output follows.
        int           rel = -1;
        int           prev, h, n;
        logic [W-1:0] m_tx = '0;
        logic [W-1:0] m_srx = '0;
        logic [W-1:0] exp_rx = '0;
        logic         exp_mosi = 1'b0;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rel = -1;
                exp_rx = '0;
                exp_mosi = 1'b0;
            end else begin
                prev = rel;
                if (start_v[g] === 1'b1 && !(prev >= 1 && prev <= L - 1)) begin
                    rel = 1;
                    m_tx = tx_v[g][W-1:0];
                    m_srx = slave_tx[g][W-1:0];
                end else if (prev >= 1 && prev < L) begin
                    rel = prev + 1;
                end else begin
                    rel = -1;
                end
                if (rel == L) exp_rx = m_srx;
                if (rel >= 1 && rel <= HP) begin
                    if (!CH) exp_mosi = bit_at(m_tx, 0);
                end else if (rel > HP && rel <= HP + 2 * W * HP) begin
                    h = (rel - HP - 1) / HP;
                    n = CH ? h / 2 : (h + 1) / 2;
                    if (n > W - 1) n = W - 1;
                    exp_mosi = bit_at(m_tx, n);
                end
            end
        end

        // Compare every output against the model on each falling clock edge.
        logic exp_sck;
        always @(negedge clk) begin
            if (rel > HP && rel <= HP + 2 * W * HP)
                exp_sck = CP ^ ((((rel - HP - 1) / HP) % 2) == 0);
            else
                exp_sck = CP;
            checkOutput($sformatf("u%0d.cs", g), 32'(cs_w), 32'(!(rel >= 1 && rel <= HP * (2 * W + 2))));
            checkOutput($sformatf("u%0d.sck", g), 32'(sck_w), 32'(exp_sck));
            checkOutput($sformatf("u%0d.busy", g), 32'(busy_w), 32'(rel >= 1 && rel <= L - 1));
            checkOutput($sformatf("u%0d.done", g), 32'(done_w), 32'(rel == L));
            checkOutput($sformatf("u%0d.mosi", g), 32'(mosi_w), 32'(exp_mosi));
            checkOutput($sformatf("u%0d.rx_data", g), 32'(rx_w), 32'(exp_rx));
            if (rel == L) begin
                checkOutput($sformatf("u%0d.slave_rx", g), srx_v[g], 32'(m_tx));
                checkOutput($sformatf("u%0d.lead_edges", g), 32'(lead_cnt[g]), 32'(W));
            end
        end
    end

    // Accept one transfer on unit idx, scramble tx_data afterwards, and
    // report the cycle (relative to acceptance) in which done was seen.
    task automatic applyStimulus(input int idx, input logic [31:0] tx, input logic [31:0] stx,
                                 output int done_at);
        @(posedge clk);
        #1;
        start_v[idx] = 1'b1;
        tx_v[idx] = tx;
        slave_tx[idx] = stx;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        tx_v[idx] = ~tx;
        done_at = -1;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            if (done_v[idx] === 1'b1) begin
                done_at = c;
                break;
            end
            @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    int done_at, ndone, first_done, second_done, cs_high, phase;

    initial begin
        for (int i = 0; i < NU; i++) begin
            start_v[i] = 1'b0;
            tx_v[i] = '0;
            slave_tx[i] = '0;
            srx_v[i] = '0;
            lead_cnt[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.cs", 32'(cs_v[0]), 32'd1);
        checkOutput("reset.sck0", 32'(sck_v[0]), 32'd0);
        checkOutput("reset.sck2", 32'(sck_v[2]), 32'd1);
        checkOutput("reset.busy", 32'(busy_v[0]), 32'd0);
        checkOutput("reset.done", 32'(done_v[0]), 32'd0);
        checkOutput("reset.mosi", 32'(mosi_v[0]), 32'd0);
        checkOutput("reset.rx", rx_v[0], 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] mode 0, 8 bit MSB");
        applyStimulus(0, 32'hA5, 32'h3C, done_at);
        checkOutput("m0.done_cycle", 32'(done_at), 32'd77);
        checkOutput("m0.rx", rx_v[0], 32'h3C);
        checkOutput("m0.slave_rx", srx_v[0], 32'hA5);
        checkOutput("m0.rising_edges", 32'(lead_cnt[0]), 32'd8);

        $display("[TB] mode 1, 12 bit LSB");
        applyStimulus(1, 32'h5A3, 32'hC0F, done_at);
        checkOutput("m1.done_cycle", 32'(done_at), 32'd109);
        checkOutput("m1.rx", rx_v[1], 32'hC0F);
        checkOutput("m1.slave_rx", srx_v[1], 32'h5A3);

        $display("[TB] mode 2, 16 bit MSB");
        checkOutput("m2.sck_idle_before", 32'(sck_v[2]), 32'd1);
        applyStimulus(2, 32'hBEEF, 32'h1357, done_at);
        checkOutput("m2.done_cycle", 32'(done_at), 32'd141);
        checkOutput("m2.rx", rx_v[2], 32'h1357);
        checkOutput("m2.slave_rx", srx_v[2], 32'hBEEF);
        checkOutput("m2.sck_idle_after", 32'(sck_v[2]), 32'd1);

        $display("[TB] mode 3, 32 bit LSB");
        applyStimulus(3, 32'h1234_5678, 32'h9ABC_DEF0, done_at);
        checkOutput("m3.done_cycle", 32'(done_at), 32'd269);
        checkOutput("m3.rx", rx_v[3], 32'h9ABC_DEF0);
        checkOutput("m3.slave_rx", srx_v[3], 32'h1234_5678);
        checkOutput("m3.sck_idle_after", 32'(sck_v[3]), 32'd1);
        checkOutput("m3.cs_after", 32'(cs_v[3]), 32'd1);

        $display("[TB] start during busy, then restart in the done cycle");
        @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        tx_v[0] = 32'h0F;
        slave_tx[0] = 32'hF0;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        ndone = 0;
        first_done = -1;
        second_done = -1;
        cs_high = 0;
        phase = 0;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (c == 5 || c == 40) begin
                start_v[0] = 1'b1;
                tx_v[0] = 32'hFF;
            end
            if (cs_v[0] === 1'b0) begin
                if (phase == 0) phase = 1;
                else if (phase == 2) phase = 3;
            end else begin
                if (phase == 1) begin
                    phase = 2;
                    cs_high = 1;
                end else if (phase == 2) begin
                    cs_high++;
                end
            end
            if (done_v[0] === 1'b1) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = c;
                    checkOutput("b2b.first_rx", rx_v[0], 32'hF0);
                    start_v[0] = 1'b1;
                    tx_v[0] = 32'h5A;
                    slave_tx[0] = 32'hC3;
                end else begin
                    second_done = c;
                end
            end
        end
        checkOutput("b2b.first_done_cycle", 32'(first_done), 32'd77);
        checkOutput("b2b.second_done_cycle", 32'(second_done), 32'd154);
        checkOutput("b2b.done_count", 32'(ndone), 32'd2);
        checkOutput("b2b.cs_high_cycles", 32'(cs_high), 32'd5);
        checkOutput("b2b.second_rx", rx_v[0], 32'hC3);
        checkOutput("b2b.second_slave_rx", srx_v[0], 32'h5A);

        $display("[TB] reset during a mode 0 transfer");
        @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        tx_v[0] = 32'h96;
        slave_tx[0] = 32'h69;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.cs", 32'(cs_v[0]), 32'd1);
        checkOutput("abort.sck", 32'(sck_v[0]), 32'd0);
        checkOutput("abort.busy", 32'(busy_v[0]), 32'd0);
        checkOutput("abort.rx", rx_v[0], 32'h0);
        checkOutput("abort.done", 32'(done_v[0]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) ndone++;
        end
        checkOutput("abort.no_done", 32'(ndone), 32'd0);
        applyStimulus(0, 32'h81, 32'h7E, done_at);
        checkOutput("abort.next_done_cycle", 32'(done_at), 32'd77);
        checkOutput("abort.next_rx", rx_v[0], 32'h7E);
        checkOutput("abort.next_slave_rx", srx_v[0], 32'h81);

        $display("[TB] HALF_PERIOD 1, mode 0");
        applyStimulus(4, 32'hFF, 32'h00, done_at);
        checkOutput("hp1.done_cycle", 32'(done_at), 32'd20);
        checkOutput("hp1.rx", rx_v[4], 32'h00);
        checkOutput("hp1.slave_rx", srx_v[4], 32'hFF);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
